// File: rtl/coinc_pkg.sv
// Shared types and constants for the delay calibrator and its per-channel capture cells.
package coinc_pkg;

  localparam int NCHAN      = 4;
  localparam int NBITS      = 8;
  localparam int LOG2_SHOTS = 2;
  localparam int WINDOW_MAX = 2**NBITS - 1;

  typedef logic [NBITS-1:0] delay_t;
  typedef delay_t [NCHAN-1:0] delay_arr_t;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_EDGE,
    WINDOW,
    COMPUTE,
    SUBTRACT,
    DONE
  } cal_state_e;

endpackage

// File: rtl/chan_offset_capture.sv
// One channel: rising-edge detect plus first-rise offset capture against the shared window counter.
module chan_offset_capture
  import coinc_pkg::*;
(
  input  logic   Clk,
  input  logic   Rst_n,
  input  logic   chan,
  input  logic   clear,
  input  logic   enable,
  input  delay_t cnt,
  output logic   rise,
  output logic   captured,
  output delay_t offset
);

  logic prev;

  assign rise = chan & ~prev;

  // prev tracks the level in every state so a channel already high at arm time never looks like an edge
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prev     <= 1'b0;
      captured <= 1'b0;
      offset   <= '0;
    end else begin
      prev <= chan;
      if (clear) begin
        captured <= 1'b0;
        offset   <= '0;
      end else if (enable && rise && !captured) begin
        captured <= 1'b1;
        offset   <= cnt;
      end
    end
  end

endmodule

// File: rtl/delay_calibrator.sv
// Measures coincident-pulse skew per channel and produces alignment delays.
// Define DELAY_CAL_AVG_EN to average 2**LOG2_SHOTS shots; otherwise a single shot is used.
module delay_calibrator
  import coinc_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [NCHAN-1:0] Channels,
  output delay_arr_t       Delays,
  output logic             Busy,
  output logic             Done,
  output logic             Error
);

`ifdef DELAY_CAL_AVG_EN
  localparam int ACC_W = NBITS + LOG2_SHOTS;
`else
  localparam int ACC_W = NBITS;
`endif

  cal_state_e state, next_state;
  delay_t     cnt;
  delay_t     max_avg, max_q;
  delay_arr_t offset, avg, avg_q;
  logic [NCHAN-1:0] rise, captured;
  logic [NCHAN-1:0][ACC_W-1:0] acc;
  logic clear, enable, any_rise, all_next, last_shot, capture_done, timeout, start_ok;
`ifdef DELAY_CAL_AVG_EN
  logic [LOG2_SHOTS-1:0] shot_cnt;
`endif

  for (genvar i = 0; i < NCHAN; i++) begin : g_cap
    chan_offset_capture u_cap (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .chan     (Channels[i]),
      .clear    (clear),
      .enable   (enable),
      .cnt      (cnt),
      .rise     (rise[i]),
      .captured (captured[i]),
      .offset   (offset[i])
    );
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // all_next folds in this cycle's rises so the shot closes in the same cycle the last channel lands
  always_comb begin
    clear        = (state == IDLE) || (state == ARM) || (state == DONE);
    enable       = (state == WAIT_EDGE) || (state == WINDOW);
    any_rise     = |rise;
    all_next     = &(captured | rise);
    start_ok     = Start && ((state == IDLE) || (state == DONE));
`ifdef DELAY_CAL_AVG_EN
    last_shot    = (shot_cnt == '1);
`else
    last_shot    = 1'b1;
`endif
    capture_done = ((state == WAIT_EDGE) && any_rise && all_next) ||
                   ((state == WINDOW) && all_next);
    timeout      = (state == WINDOW) && !all_next && (cnt == delay_t'(WINDOW_MAX));
    next_state   = state;
    case (state)
      IDLE, DONE: if (start_ok) next_state = ARM;
      ARM:        if (Channels == '0) next_state = WAIT_EDGE;
      WAIT_EDGE:  if (capture_done) next_state = last_shot ? COMPUTE : ARM;
                  else if (any_rise) next_state = WINDOW;
      WINDOW:     if (capture_done) next_state = last_shot ? COMPUTE : ARM;
                  else if (timeout) next_state = DONE;
      COMPUTE:    next_state = SUBTRACT;
      SUBTRACT:   next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    max_avg = '0;
    for (int i = 0; i < NCHAN; i++) begin
`ifdef DELAY_CAL_AVG_EN
      avg[i] = delay_t'(acc[i] >> LOG2_SHOTS);
`else
      avg[i] = acc[i];
`endif
      if (avg[i] > max_avg) max_avg = avg[i];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      avg_q  <= '0;
      max_q  <= '0;
      Delays <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Error  <= 1'b0;
`ifdef DELAY_CAL_AVG_EN
      shot_cnt <= '0;
`endif
    end else begin
      Done <= 1'b0;
      if (start_ok) begin
        Busy  <= 1'b1;
        Error <= 1'b0;
        acc   <= '0;
        cnt   <= '0;
`ifdef DELAY_CAL_AVG_EN
        shot_cnt <= '0;
`endif
      end
      case (state)
        ARM:       cnt <= '0;
        WAIT_EDGE: if (any_rise) cnt <= delay_t'(1);
        WINDOW:    cnt <= cnt + 1'b1;
        default:   ;
      endcase
      // channels rising in the closing cycle have not registered their offset yet, so take cnt directly
      if (capture_done) begin
        for (int i = 0; i < NCHAN; i++)
          acc[i] <= acc[i] + ACC_W'(captured[i] ? offset[i] : cnt);
`ifdef DELAY_CAL_AVG_EN
        shot_cnt <= shot_cnt + 1'b1;
`endif
      end
      if (timeout) begin
        Error  <= 1'b1;
        Delays <= '0;
        Done   <= 1'b1;
        Busy   <= 1'b0;
      end
      if (state == COMPUTE) begin
        avg_q <= avg;
        max_q <= max_avg;
      end
      if (state == SUBTRACT) begin
        for (int i = 0; i < NCHAN; i++)
          Delays[i] <= max_q - avg_q[i];
        Done <= 1'b1;
        Busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_delay_calibrator.sv
// Scoreboard bench for delay_calibrator; works with or without DELAY_CAL_AVG_EN.
module tb_delay_calibrator;
  import coinc_pkg::*;

`ifdef DELAY_CAL_AVG_EN
  localparam int SHOTS = 2**LOG2_SHOTS;
`else
  localparam int SHOTS = 1;
`endif

  typedef int offs_t [NCHAN];
  typedef struct {
    delay_arr_t delays;
    logic       err;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst_n, Start;
  logic [NCHAN-1:0] Channels;
  delay_arr_t Delays;
  logic Busy, Done, Error;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  always #5 Clk = ~Clk;

  delay_calibrator dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Start    (Start),
    .Channels (Channels),
    .Delays   (Delays),
    .Busy     (Busy),
    .Done     (Done),
    .Error    (Error)
  );

  // Reference: average the summed offsets, then align everything to the latest channel
  function automatic delay_arr_t model_delays(input offs_t sum);
    int avg[NCHAN];
    int mx;
    delay_arr_t d;
    mx = 0;
    for (int i = 0; i < NCHAN; i++) begin
      avg[i] = sum[i] / SHOTS;
      if (avg[i] > mx) mx = avg[i];
    end
    for (int i = 0; i < NCHAN; i++) d[i] = delay_t'(mx - avg[i]);
    return d;
  endfunction

  function automatic offs_t scale(input offs_t o);
    offs_t s;
    for (int i = 0; i < NCHAN; i++) s[i] = o[i] * SHOTS;
    return s;
  endfunction

  task automatic start_cal();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Negative offset means the channel never rises in this shot
  task automatic drive_shot(input offs_t o, input bit start_mid);
    int maxo;
    maxo = 0;
    Channels = '0;
    repeat (3) @(negedge Clk);
    for (int i = 0; i < NCHAN; i++) if (o[i] > maxo) maxo = o[i];
    for (int k = 0; k <= maxo; k++) begin
      for (int i = 0; i < NCHAN; i++) if (o[i] >= 0 && k >= o[i]) Channels[i] = 1'b1;
      Start = start_mid && (k == 1);
      @(negedge Clk);
    end
    Start = 1'b0;
  endtask

  task automatic run_shots(input offs_t o, input bit start_mid);
    for (int s = 0; s < SHOTS; s++) drive_shot(o, start_mid && (s == 0));
  endtask

  task automatic wait_done(input int maxc, output int n, output bit got);
    n = 0;
    got = 1'b0;
    while (n < maxc && !got) begin
      if (Done === 1'b1) got = 1'b1;
      else begin
        @(negedge Clk);
        n++;
      end
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    Start = 1'b0;
    Channels = '0;
    repeat (3) @(negedge Clk);
    total++; if (Delays !== '0) begin bad++; $display("[TB] FAIL reset_delays got=%h want=0", Delays); end
    total++; if (Busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", Busy); end
    total++; if (Done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", Done); end
    total++; if (Error !== 1'b0) begin bad++; $display("[TB] FAIL reset_error got=%b want=0", Error); end
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_skew();
    offs_t o;
    exp_t e, g;
    int n;
    bit got;
    o = '{0, 3, 7, 1};
    e.delays = model_delays(scale(o));
    e.err = 1'b0;
    exp_q.push_back(e);
    start_cal();
    total++; if (Busy !== 1'b1) begin bad++; $display("[TB] FAIL skew_busy got=%b want=1", Busy); end
    run_shots(o, 1'b0);
    wait_done(40, n, got);
    g = exp_q.pop_front();
    total++; if (!got) begin bad++; $display("[TB] FAIL skew_done_seen got=0 want=1"); end
    total++; if (Delays !== g.delays) begin bad++; $display("[TB] FAIL skew_delays got=%h want=%h", Delays, g.delays); end
    total++; if (Error !== g.err) begin bad++; $display("[TB] FAIL skew_error got=%b want=%b", Error, g.err); end
    total++; if (n + 1 != 3) begin bad++; $display("[TB] FAIL skew_latency got=%0d want=3", n + 1); end
    @(negedge Clk);
    total++; if (Done !== 1'b0 || Busy !== 1'b0) begin bad++; $display("[TB] FAIL skew_pulse got done=%b busy=%b want 0 0", Done, Busy); end
  endtask

  task automatic test_coincident();
    offs_t o;
    exp_t e, g;
    int n;
    bit got;
    o = '{0, 0, 0, 0};
    e.delays = model_delays(scale(o));
    e.err = 1'b0;
    exp_q.push_back(e);
    start_cal();
    run_shots(o, 1'b0);
    wait_done(40, n, got);
    g = exp_q.pop_front();
    total++; if (!got) begin bad++; $display("[TB] FAIL coinc_done_seen got=0 want=1"); end
    total++; if (Delays !== g.delays) begin bad++; $display("[TB] FAIL coinc_delays got=%h want=%h", Delays, g.delays); end
    total++; if (n + 1 != 3) begin bad++; $display("[TB] FAIL coinc_latency got=%0d want=3", n + 1); end
  endtask

  task automatic test_timeout();
    offs_t o;
    exp_t e, g;
    int n;
    bit got;
    o = '{0, 1, 2, -1};
    e.delays = '0;
    e.err = 1'b1;
    exp_q.push_back(e);
    start_cal();
    drive_shot(o, 1'b0);
    wait_done(300, n, got);
    g = exp_q.pop_front();
    total++; if (!got) begin bad++; $display("[TB] FAIL timeout_done_seen got=0 want=1"); end
    // cnt hits 255 in the 255th cycle after the edge; the flag shows on the following one
    total++; if (n + 3 < 255 || n + 3 > 256) begin bad++; $display("[TB] FAIL timeout_cycles got=%0d want=255..256", n + 3); end
    total++; if (Error !== g.err) begin bad++; $display("[TB] FAIL timeout_error got=%b want=%b", Error, g.err); end
    total++; if (Delays !== g.delays) begin bad++; $display("[TB] FAIL timeout_delays got=%h want=%h", Delays, g.delays); end
    @(negedge Clk);
    total++; if (Busy !== 1'b0 || Done !== 1'b0 || Error !== 1'b1) begin bad++; $display("[TB] FAIL timeout_after got busy=%b done=%b err=%b want 0 0 1", Busy, Done, Error); end
  endtask

  task automatic test_stuck_high();
    offs_t o;
    exp_t e, g;
    int n, seen;
    bit got;
    o = '{2, 0, 5, 1};
    e.delays = model_delays(scale(o));
    e.err = 1'b0;
    exp_q.push_back(e);
    Channels = 4'b0100;
    start_cal();
    total++; if (Error !== 1'b0 || Busy !== 1'b1) begin bad++; $display("[TB] FAIL stuck_start got err=%b busy=%b want 0 1", Error, Busy); end
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) Channels[0] = 1'b1;
      if (k == 2) Channels[3] = 1'b1;
      if (k == 4) Channels[1] = 1'b1;
      Start = (k == 5);
      @(negedge Clk);
      if (Done === 1'b1) seen++;
    end
    Start = 1'b0;
    total++; if (seen != 0) begin bad++; $display("[TB] FAIL stuck_no_measure got=%0d want=0", seen); end
    run_shots(o, 1'b1);
    wait_done(40, n, got);
    g = exp_q.pop_front();
    total++; if (!got) begin bad++; $display("[TB] FAIL stuck_done_seen got=0 want=1"); end
    total++; if (Delays !== g.delays) begin bad++; $display("[TB] FAIL stuck_delays got=%h want=%h", Delays, g.delays); end
  endtask

  task automatic test_reset_mid();
    offs_t o;
    exp_t e, g;
    int n, seen;
    bit got;
    start_cal();
    Channels = '0;
    repeat (3) @(negedge Clk);
    Channels[0] = 1'b1;
    repeat (5) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    total++; if (Delays !== '0 || Busy !== 1'b0 || Done !== 1'b0 || Error !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_outputs got d=%h b=%b dn=%b e=%b want 0", Delays, Busy, Done, Error); end
    @(negedge Clk);
    Rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      Channels = (k < 10) ? 4'b1111 : 4'b0000;
      @(negedge Clk);
      if (Done === 1'b1 || Busy === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("[TB] FAIL rstmid_idle got=%0d want=0", seen); end
    o = '{1, 0, 0, 2};
    e.delays = model_delays(scale(o));
    e.err = 1'b0;
    exp_q.push_back(e);
    start_cal();
    run_shots(o, 1'b0);
    wait_done(40, n, got);
    g = exp_q.pop_front();
    total++; if (!got || Delays !== g.delays) begin bad++; $display("[TB] FAIL rstmid_recal got done=%b d=%h want 1 %h", got, Delays, g.delays); end
  endtask

`ifdef DELAY_CAL_AVG_EN
  task automatic test_avg();
    offs_t o, sum;
    exp_t e, g;
    int n;
    bit got;
    int ch1[4];
    ch1 = '{2, 3, 3, 4};
    sum = '{0, 0, 0, 0};
    for (int s = 0; s < SHOTS; s++) sum[1] += ch1[s];
    e.delays = model_delays(sum);
    e.err = 1'b0;
    exp_q.push_back(e);
    start_cal();
    for (int s = 0; s < SHOTS; s++) begin
      o = '{0, ch1[s], 0, 0};
      drive_shot(o, 1'b0);
    end
    wait_done(40, n, got);
    g = exp_q.pop_front();
    total++; if (!got) begin bad++; $display("[TB] FAIL avg_done_seen got=0 want=1"); end
    total++; if (Delays !== g.delays) begin bad++; $display("[TB] FAIL avg_delays got=%h want=%h", Delays, g.delays); end
    total++; if (n + 1 != 3) begin bad++; $display("[TB] FAIL avg_latency got=%0d want=3", n + 1); end
  endtask

  task automatic test_avg_timeout();
    offs_t o, miss;
    exp_t e, g;
    int n, seen;
    bit got;
    o = '{0, 1, 2, 3};
    miss = '{0, 1, 2, -1};
    e.delays = '0;
    e.err = 1'b1;
    exp_q.push_back(e);
    start_cal();
    drive_shot(o, 1'b0);
    drive_shot(o, 1'b0);
    drive_shot(miss, 1'b0);
    wait_done(300, n, got);
    g = exp_q.pop_front();
    total++; if (!got || Error !== g.err || Delays !== g.delays) begin bad++; $display("[TB] FAIL avgto_result got done=%b e=%b d=%h want 1 1 0", got, Error, Delays); end
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      Channels = (k < 5) ? 4'b0000 : 4'b1111;
      @(negedge Clk);
      if (Done === 1'b1 || Busy === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("[TB] FAIL avgto_no_shot4 got=%0d want=0", seen); end
    e.delays = model_delays(scale(o));
    e.err = 1'b0;
    exp_q.push_back(e);
    start_cal();
    total++; if (Error !== 1'b0) begin bad++; $display("[TB] FAIL avgto_err_clear got=%b want=0", Error); end
    run_shots(o, 1'b0);
    wait_done(40, n, got);
    g = exp_q.pop_front();
    total++; if (!got || Delays !== g.delays || Error !== g.err) begin bad++; $display("[TB] FAIL avgto_recal got done=%b d=%h e=%b want 1 %h 0", got, Delays, Error, g.delays); end
  endtask
`endif

  initial begin
    test_reset();
    test_skew();
    test_coincident();
    test_timeout();
    test_stuck_high();
    test_reset_mid();
`ifdef DELAY_CAL_AVG_EN
    test_avg();
    test_avg_timeout();
`endif
    total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
